// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - Shared FSM state type, policy codes and bus_state packing for the bus arbiter
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      BUSY    = 2'd2,
      RELEASE = 2'd3
   } arb_state_e;

   localparam int RR_FIXED = 0;
   localparam int RR_ROUND = 1;

   function automatic logic [31:0] pack_bus_state(input logic [15:0] sid,
                                                  input logic [15:0] mid,
                                                  input int          m_w);
      return ({16'd0, sid} << m_w) | {16'd0, mid};
   endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// rtl/arb_rr_picker.sv - Combinational rotate-priority picker: first valid index at or after start, wrapping
module arb_rr_picker #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] valid,
   input  logic [W-1:0] start,
   output logic [W-1:0] winner,
   output logic         found
);

   logic [2*N-1:0] rotated;
   logic [W:0]     sum;

   // Doubling the vector turns the wrap-around search into a plain low-to-high scan.
   always_comb begin
      rotated = {valid, valid} >> start;
      winner  = '0;
      found   = 1'b0;
      sum     = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rotated[k]) begin
            found  = 1'b1;
            sum    = {1'b0, start} + (W+1)'(k);
            winner = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
         end
      end
   end

endmodule

// File: rtl/arbiter_core_rr.sv
// rtl/arbiter_core_rr.sv - Central bus arbiter (fixed/round-robin) with grant timeout; ARB_PREEMPT_EN adds hold-limit preemption
module arbiter_core_rr
   import arb_pkg::*;
#(
   parameter int NO_MASTERS = 2,
   parameter int NO_SLAVES  = 3,
   parameter int THRESH     = 10000000,
   parameter int RR_MODE    = 1,
   parameter int S_ID_WIDTH = $clog2(NO_SLAVES+1),
   parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
   input  logic                                  clk,
   input  logic                                  rstN,
   input  logic [NO_MASTERS-1:0]                 req,
   input  logic [NO_MASTERS-1:0][S_ID_WIDTH-1:0] slave_id,
   input  logic [NO_MASTERS-1:0]                 done,
   input  logic                                  ready,
   output logic [NO_MASTERS-1:0]                 grant,
   output logic [S_ID_WIDTH+M_ID_WIDTH-1:0]      bus_state,
   output logic                                  timeout,
   output logic                                  busy
);

   localparam int               CNT_W   = $clog2(THRESH+1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(THRESH);
   localparam int               BS_W    = S_ID_WIDTH + M_ID_WIDTH;

`ifdef ARB_PREEMPT_EN
   localparam bit PREEMPT_EN = 1'b1;
`else
   localparam bit PREEMPT_EN = 1'b0;
`endif

   arb_state_e                state;
   logic [M_ID_WIDTH-1:0]     owner;
   logic [M_ID_WIDTH-1:0]     rr_ptr;
   logic [M_ID_WIDTH-1:0]     ptr_next;
   logic [M_ID_WIDTH-1:0]     pick_start;
   logic [M_ID_WIDTH-1:0]     pick_idx;
   logic                      pick_found;
   logic [NO_MASTERS-1:0]     req_valid;
   logic [NO_MASTERS-1:0]     owner_oh;
   logic [CNT_W-1:0]          cnt;
   logic [CNT_W-1:0]          cnt_inc;
   logic                      cnt_hit;
   logic                      owner_req;
   logic                      owner_done;
   logic                      others_pending;
   logic                      rel_now;
   logic                      tmo_now;

   // Requests aimed at slave 0 or beyond the last slave never compete.
   always_comb begin
      req_valid = '0;
      for (int i = 0; i < NO_MASTERS; i++) begin
         req_valid[i] = req[i] && (slave_id[i] != '0) && (int'(slave_id[i]) <= NO_SLAVES);
      end
   end

   assign pick_start = (RR_MODE == RR_ROUND) ? rr_ptr : '0;

   arb_rr_picker #(
      .N (NO_MASTERS),
      .W (M_ID_WIDTH)
   ) u_picker (
      .valid  (req_valid),
      .start  (pick_start),
      .winner (pick_idx),
      .found  (pick_found)
   );

   assign owner_oh       = NO_MASTERS'(1) << owner;
   assign owner_req      = req[owner];
   assign owner_done     = done[owner];
   assign others_pending = |(req_valid & ~owner_oh);
   assign ptr_next       = (owner == M_ID_WIDTH'(NO_MASTERS-1)) ? '0 : owner + 1'b1;
   assign cnt_inc        = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
   assign cnt_hit        = (cnt_inc == CNT_MAX);

   // Owner abort takes precedence over the limit, so a dropped request never reports a timeout.
   always_comb begin
      rel_now = 1'b0;
      tmo_now = 1'b0;
      if (state == GRANT && !ready) begin
         if (!owner_req) begin
            rel_now = 1'b1;
         end else if (cnt_hit) begin
            rel_now = 1'b1;
            tmo_now = 1'b1;
         end
      end else if (state == BUSY) begin
         if (owner_done) begin
            rel_now = 1'b1;
         end else if (PREEMPT_EN && cnt_hit && others_pending) begin
            rel_now = 1'b1;
            tmo_now = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         cnt       <= '0;
         grant     <= '0;
         bus_state <= '0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (pick_found) begin
                  state     <= GRANT;
                  owner     <= pick_idx;
                  grant     <= NO_MASTERS'(1) << pick_idx;
                  bus_state <= BS_W'(pack_bus_state(16'(slave_id[pick_idx]), 16'(pick_idx), M_ID_WIDTH));
                  busy      <= 1'b1;
               end
            end
            GRANT, BUSY: begin
               if (rel_now) begin
                  state     <= RELEASE;
                  grant     <= '0;
                  bus_state <= '0;
                  busy      <= 1'b0;
                  timeout   <= tmo_now;
               end else if (state == GRANT && ready) begin
                  state <= BUSY;
                  cnt   <= '0;
               end else if (state == GRANT || PREEMPT_EN) begin
                  cnt <= cnt_inc;
               end
            end
            RELEASE: begin
               state  <= IDLE;
               rr_ptr <= ptr_next;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_arbiter_core_rr.sv
// tb/tb_arbiter_core_rr.sv - Self-checking bench: round-robin and fixed-priority arbiters against a cycle model
module tb_arbiter_core_rr;

   localparam int NM = 2;
   localparam int NS = 3;
   localparam int TH = 8;
`ifdef ARB_PREEMPT_EN
   localparam int PRE = 1;
`else
   localparam int PRE = 0;
`endif

   logic            clk = 1'b0;
   logic            rstN;
   logic [1:0]      req;
   logic [1:0][1:0] sid;
   logic [1:0]      done;
   logic            ready;
   logic [1:0]      g_rr, g_fp;
   logic [2:0]      bs_rr, bs_fp;
   logic            to_rr, to_fp, by_rr, by_fp;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   arbiter_core_rr #(.NO_MASTERS(NM), .NO_SLAVES(NS), .THRESH(TH), .RR_MODE(1)) dut_rr (
      .clk(clk), .rstN(rstN), .req(req), .slave_id(sid), .done(done), .ready(ready),
      .grant(g_rr), .bus_state(bs_rr), .timeout(to_rr), .busy(by_rr));

   arbiter_core_rr #(.NO_MASTERS(NM), .NO_SLAVES(NS), .THRESH(TH), .RR_MODE(0)) dut_fp (
      .clk(clk), .rstN(rstN), .req(req), .slave_id(sid), .done(done), .ready(ready),
      .grant(g_fp), .bus_state(bs_fp), .timeout(to_fp), .busy(by_fp));

   // ph: 0 bus free, 1 granted awaiting ready, 2 owned, 3 gap cycle
   typedef struct {
      int ph;
      int own;
      int ptr;
      int cnt;
      int sid;
      int tmo;
   } mst_t;

   mst_t ms [2];

   function automatic bit vreq(int i);
      return req[i] && (int'(sid[i]) >= 1) && (int'(sid[i]) <= NS);
   endfunction

   function automatic bit others(int own);
      bit any = 1'b0;
      for (int i = 0; i < NM; i++) if (i != own && vreq(i)) any = 1'b1;
      return any;
   endfunction

   function automatic mst_t step(mst_t s, bit rr);
      mst_t n = s;
      n.tmo = 0;
      case (s.ph)
         0: begin
            int start = rr ? s.ptr : 0;
            for (int k = 0; k < NM; k++) begin
               int i = (start + k) % NM;
               if (n.ph == 0 && vreq(i)) begin
                  n.ph = 1; n.own = i; n.sid = int'(sid[i]); n.cnt = 0;
               end
            end
         end
         1: begin
            if (ready) begin
               n.ph = 2; n.cnt = 0;
            end else if (!req[s.own]) begin
               n.ph = 3;
            end else begin
               n.cnt = s.cnt + 1;
               if (n.cnt == TH) begin n.ph = 3; n.tmo = 1; end
            end
         end
         2: begin
            if (done[s.own]) begin
               n.ph = 3;
            end else if (PRE == 1) begin
               n.cnt = (s.cnt + 1 > TH) ? TH : s.cnt + 1;
               if (n.cnt == TH && others(s.own)) begin n.ph = 3; n.tmo = 1; end
            end
         end
         default: begin
            n.ph = 0; n.ptr = (s.own + 1) % NM;
         end
      endcase
      return n;
   endfunction

   function automatic int exp_g(mst_t s);
      return (s.ph == 1 || s.ph == 2) ? (1 << s.own) : 0;
   endfunction

   function automatic int exp_bs(mst_t s);
      return (s.ph == 1 || s.ph == 2) ? (s.sid * 2 + s.own) : 0;
   endfunction

   function automatic int exp_busy(mst_t s);
      return (s.ph == 1 || s.ph == 2) ? 1 : 0;
   endfunction

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ms[0] <= '{ph:0, own:0, ptr:0, cnt:0, sid:0, tmo:0};
         ms[1] <= '{ph:0, own:0, ptr:0, cnt:0, sid:0, tmo:0};
      end else begin
         ms[0] <= step(ms[0], 1'b1);
         ms[1] <= step(ms[1], 1'b0);
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("rr_grant",   int'(g_rr),  exp_g(ms[0]));
      check("rr_bus",     int'(bs_rr), exp_bs(ms[0]));
      check("rr_busy",    int'(by_rr), exp_busy(ms[0]));
      check("rr_timeout", int'(to_rr), ms[0].tmo);
      check("fp_grant",   int'(g_fp),  exp_g(ms[1]));
      check("fp_bus",     int'(bs_fp), exp_bs(ms[1]));
      check("fp_busy",    int'(by_fp), exp_busy(ms[1]));
      check("fp_timeout", int'(to_fp), ms[1].tmo);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  exp_rr [3];
      int  lat;
      bit  seen;
      bit  any;
      exp_rr = '{1, 2, 1};

      rstN = 1'b0; req = 2'b11; sid = {2'd1, 2'd1}; done = 2'b00; ready = 1'b0;
      repeat (3) tick();
      check("reset_grant", int'(g_rr), 0);
      check("reset_bus", int'(bs_rr), 0);
      check("reset_busy", int'(by_rr), 0);
      check("reset_timeout", int'(to_rr), 0);
      req = 2'b00; rstN = 1'b1;
      tick();

      // single grant to master 1, slave 2
      req = 2'b10; sid = {2'd2, 2'd0};
      tick();
      check("single_grant", int'(g_rr), 2);
      check("single_bus", int'(bs_rr), 5);
      check("single_busy", int'(by_rr), 1);
      ready = 1'b1; tick(); ready = 1'b0;
      tick(); tick();
      done = 2'b10; tick(); done = 2'b00; req = 2'b00;
      check("single_release_bus", int'(bs_rr), 0);
      check("single_release_busy", int'(by_rr), 0);
      tick();

      // both request continuously: round-robin alternates, fixed priority stays on 0
      sid = {2'd3, 2'd1}; req = 2'b11;
      for (int t = 0; t < 3; t++) begin
         tick();
         check("rr_owner_seq", int'(g_rr), exp_rr[t]);
         check("fp_owner_seq", int'(g_fp), 1);
         ready = 1'b1; tick(); ready = 1'b0;
         done = 2'b11; if (t == 2) req = 2'b00;
         tick(); done = 2'b00;
         check("gap_release", int'(g_rr), 0);
         tick();
         check("gap_idle", int'(g_rr), 0);
      end

      // grant timeout: ready never arrives
      sid = {2'd0, 2'd2}; req = 2'b01;
      lat = 0; seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         tick();
         if (to_rr) begin seen = 1'b1; lat = k; end
      end
      check("timeout_seen", int'(seen), 1);
      check("timeout_latency", lat, 9);
      check("timeout_grant_dropped", int'(g_rr), 0);
      req = 2'b00;
      tick();
      check("timeout_one_cycle", int'(to_rr), 0);
      tick();

      // owner withdraws before ready: release without timeout
      sid = {2'd0, 2'd1}; req = 2'b01;
      tick();
      check("abort_grant", int'(g_rr), 1);
      req = 2'b00;
      tick();
      check("abort_no_timeout", int'(to_rr), 0);
      tick();

      // invalid slave ids are never granted; highest legal id is
      sid = {2'd0, 2'd0}; req = 2'b11; any = 1'b0;
      repeat (10) begin
         tick();
         any = any | (|g_rr) | (|g_fp);
      end
      check("invalid_never_granted", int'(any), 0);
      sid = {2'd0, 2'd3};
      tick();
      check("max_id_grant", int'(g_fp), 1);
      check("max_id_bus", int'(bs_fp), 6);
      req = 2'b00;
      tick(); tick();

      // long hold by master 0 while master 1 waits
      sid = {2'd2, 2'd1}; req = 2'b01;
      tick();
      ready = 1'b1; tick(); ready = 1'b0;
      req = 2'b10; seen = 1'b0;
      repeat (10) begin
         tick();
         if (to_rr) seen = 1'b1;
      end
      check("hold_rr_owner", int'(g_rr), PRE ? 2 : 1);
      check("hold_fp_owner", int'(g_fp), PRE ? 2 : 1);
      check("hold_timeout", int'(seen), PRE);
      done = 2'b11; tick(); done = 2'b00; req = 2'b00;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got no finish expected finish before 50000");
      $fatal(1);
   end

endmodule
